// File: rtl/spi_responder_if.sv
`default_nettype none
// spi_responder_if: SPI pins plus word-level transmit/receive signals of the responder.
// Rev 1.0
interface spi_responder_if #(
  parameter int DATA_BITS = 8
);
  logic                 SCK;
  logic                 SS;
  logic                 MOSI;
  logic                 MISO;
  logic                 miso_oe;
  logic [DATA_BITS-1:0] word_0_in;
  logic [DATA_BITS-1:0] word_1_in;
  logic [DATA_BITS-1:0] word_2_in;
  logic [DATA_BITS-1:0] word_3_in;
  logic [DATA_BITS-1:0] word_0_out;
  logic [DATA_BITS-1:0] word_1_out;
  logic [DATA_BITS-1:0] word_2_out;
  logic [DATA_BITS-1:0] word_3_out;
  logic                 rx_valid;
  logic [1:0]           rx_index;
  logic                 frame_done;
  logic [2:0]           words_rcvd;
  logic                 overrun;

  modport master (
    output SCK, SS, MOSI, word_0_in, word_1_in, word_2_in, word_3_in,
    input  MISO, miso_oe, word_0_out, word_1_out, word_2_out, word_3_out,
    input  rx_valid, rx_index, frame_done, words_rcvd, overrun
  );

  modport slave (
    input  SCK, SS, MOSI, word_0_in, word_1_in, word_2_in, word_3_in,
    output MISO, miso_oe, word_0_out, word_1_out, word_2_out, word_3_out,
    output rx_valid, rx_index, frame_done, words_rcvd, overrun
  );
endinterface
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// spi_responder: SPI slave endpoint exchanging fixed WORDS-word frames, pins oversampled in clk.
// Rev 1.0
module spi_responder #(
  parameter int DATA_BITS = 8,
  parameter int WORDS     = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 1,
  parameter int LSBF      = 0
) (
  input  logic           clk,
  input  logic           n_rst,
  spi_responder_if.slave bus
);
  localparam int   C_RCW      = $clog2(DATA_BITS);
  localparam int   C_TCW      = $clog2(DATA_BITS + 1);
  localparam int   C_IW       = $clog2(WORDS + 2);
  localparam int   C_XW       = $clog2(WORDS);
  localparam logic C_SCK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_sck_sync, r_ss_sync, r_mosi_sync;
  logic                 r_sample, r_launch, r_ss_rise, r_ss_fall;
  logic [DATA_BITS-1:0] r_tx_buf [WORDS];
  logic [DATA_BITS-1:0] r_tx_shift, r_rx_shift;
  logic [C_TCW-1:0]     r_tx_cnt;
  logic [C_RCW-1:0]     r_rx_cnt;
  logic [C_IW-1:0]      r_tx_idx, r_rx_idx;
  logic                 r_ovr;
  logic                 r_miso, r_miso_oe, r_rx_valid, r_frame_done, r_overrun;
  logic [C_XW-1:0]      r_rx_index;
  logic [C_IW-1:0]      r_words_rcvd;
  logic [DATA_BITS-1:0] r_word_out [WORDS];

  logic [DATA_BITS-1:0] w_word_in [WORDS];
  logic                 w_sck_rise, w_sck_fall, w_lead, w_trail, w_tx_live;
  logic [C_IW-1:0]      w_tx_next_idx;
  logic [DATA_BITS-1:0] w_tx_next_word, w_rx_word;

  function automatic logic first_bit(input logic [DATA_BITS-1:0] w);
    return (LSBF != 0) ? w[0] : w[DATA_BITS-1];
  endfunction

  function automatic logic [DATA_BITS-1:0] shift_out(input logic [DATA_BITS-1:0] w);
    return (LSBF != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign w_word_in[0] = bus.word_0_in;
  assign w_word_in[1] = bus.word_1_in;
  assign w_word_in[2] = bus.word_2_in;
  assign w_word_in[3] = bus.word_3_in;

  // Index 1 of each sync chain is the synchronised level, index 2 its one-clk delay.
  assign w_sck_rise     = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall     = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_lead         = (CPOL != 0) ? w_sck_fall : w_sck_rise;
  assign w_trail        = (CPOL != 0) ? w_sck_rise : w_sck_fall;
  assign w_tx_live      = (r_rx_idx < C_IW'(WORDS));
  assign w_tx_next_idx  = (r_tx_idx == C_IW'(WORDS)) ? r_tx_idx : r_tx_idx + 1'b1;
  assign w_tx_next_word = (w_tx_next_idx < C_IW'(WORDS)) ? r_tx_buf[w_tx_next_idx[C_XW-1:0]] : '0;
  // MOSI delay stage has the same age as the SCK history behind the registered sample pulse.
  assign w_rx_word      = (LSBF != 0) ? {r_mosi_sync[2], r_rx_shift[DATA_BITS-1:1]}
                                      : {r_rx_shift[DATA_BITS-2:0], r_mosi_sync[2]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= WAIT_IDLE;
      r_sck_sync   <= {3{C_SCK_IDLE}};
      r_ss_sync    <= '0;
      r_mosi_sync  <= '0;
      r_sample     <= 1'b0;
      r_launch     <= 1'b0;
      r_ss_rise    <= 1'b0;
      r_ss_fall    <= 1'b0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_tx_cnt     <= '0;
      r_rx_cnt     <= '0;
      r_tx_idx     <= '0;
      r_rx_idx     <= '0;
      r_ovr        <= 1'b0;
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_index   <= '0;
      r_frame_done <= 1'b0;
      r_words_rcvd <= '0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_tx_buf[i]   <= '0;
        r_word_out[i] <= '0;
      end
    end else begin
      r_sck_sync   <= {r_sck_sync[1:0], bus.SCK};
      r_ss_sync    <= {r_ss_sync[1:0], bus.SS};
      r_mosi_sync  <= {r_mosi_sync[1:0], bus.MOSI};
      r_sample     <= (CPHA != 0) ? w_trail : w_lead;
      r_launch     <= (CPHA != 0) ? w_lead : w_trail;
      r_ss_rise    <= r_ss_sync[1] & ~r_ss_sync[2];
      r_ss_fall    <= ~r_ss_sync[1] & r_ss_sync[2];
      r_rx_valid   <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        WAIT_IDLE: begin
          if (r_ss_sync[1]) r_state <= IDLE;
        end
        IDLE: begin
          if (r_ss_fall) begin
            for (int i = 0; i < WORDS; i++) r_tx_buf[i] <= w_word_in[i];
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_tx_idx   <= '0;
            r_ovr      <= 1'b0;
            r_miso_oe  <= 1'b1;
            r_state    <= ACTIVE;
            if (CPHA == 0) begin
              r_miso     <= first_bit(w_word_in[0]);
              r_tx_shift <= shift_out(w_word_in[0]);
              r_tx_cnt   <= C_TCW'(1);
            end else begin
              r_miso     <= 1'b0;
              r_tx_shift <= w_word_in[0];
              r_tx_cnt   <= '0;
            end
          end
        end
        ACTIVE: begin
          // SS rise wins over a coincident sample; a partial word is simply dropped.
          if (r_ss_rise) begin
            r_frame_done <= 1'b1;
            r_words_rcvd <= (r_rx_idx > C_IW'(WORDS)) ? C_IW'(WORDS) : r_rx_idx;
            r_overrun    <= r_ovr;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_state      <= IDLE;
          end else begin
            if (r_launch) begin
              if (r_tx_cnt == C_TCW'(DATA_BITS)) begin
                r_tx_idx   <= w_tx_next_idx;
                r_tx_shift <= shift_out(w_tx_next_word);
                r_tx_cnt   <= C_TCW'(1);
                r_miso     <= first_bit(w_tx_next_word) & w_tx_live;
              end else begin
                r_tx_shift <= shift_out(r_tx_shift);
                r_tx_cnt   <= r_tx_cnt + 1'b1;
                r_miso     <= first_bit(r_tx_shift) & w_tx_live;
              end
            end
            if (r_sample) begin
              r_rx_shift <= w_rx_word;
              if (r_rx_cnt == C_RCW'(DATA_BITS - 1)) begin
                r_rx_cnt <= '0;
                if (r_rx_idx < C_IW'(WORDS)) begin
                  r_word_out[r_rx_idx[C_XW-1:0]] <= w_rx_word;
                  r_rx_valid <= 1'b1;
                  r_rx_index <= r_rx_idx[C_XW-1:0];
                end
                if (r_rx_idx == C_IW'(WORDS)) r_ovr <= 1'b1;
                if (r_rx_idx != C_IW'(WORDS + 1)) r_rx_idx <= r_rx_idx + 1'b1;
                if (r_rx_idx >= C_IW'(WORDS - 1)) r_miso <= 1'b0;
              end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.MISO       = r_miso;
  assign bus.miso_oe    = r_miso_oe;
  assign bus.word_0_out = r_word_out[0];
  assign bus.word_1_out = r_word_out[1];
  assign bus.word_2_out = r_word_out[2];
  assign bus.word_3_out = r_word_out[3];
  assign bus.rx_valid   = r_rx_valid;
  assign bus.rx_index   = r_rx_index;
  assign bus.frame_done = r_frame_done;
  assign bus.words_rcvd = r_words_rcvd;
  assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// tb_spi_responder: table-driven and randomized SPI frames checked against a frame-level model.
// Rev 1.0
module tb_spi_responder;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  spi_responder_if #(.DATA_BITS(8)) bus_a ();
  spi_responder_if #(.DATA_BITS(8)) bus_b ();

  spi_responder #(.DATA_BITS(8), .WORDS(4), .CPOL(0), .CPHA(1), .LSBF(0)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a));
  spi_responder #(.DATA_BITS(8), .WORDS(4), .CPOL(0), .CPHA(0), .LSBF(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b));

  typedef struct {
    logic [31:0] tx;
    logic [47:0] rx;
    int          nw;
    int          pb;
    bit          chg;
    logic [7:0]  newv;
    int          rcvd;
    bit          ovr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  int          viol   = 0;
  logic [2:0]  fd_rcvd;
  logic        fd_ovr;
  logic [9:0]  rxq[$];
  logic [7:0]  exp_word[4];
  vec_t        tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] word_a(input logic [1:0] i);
    case (i)
      2'd0:    return bus_a.word_0_out;
      2'd1:    return bus_a.word_1_out;
      2'd2:    return bus_a.word_2_out;
      default: return bus_a.word_3_out;
    endcase
  endfunction

  function automatic logic [41:0] out_vec_a();
    return {bus_a.MISO, bus_a.miso_oe, bus_a.word_0_out, bus_a.word_1_out, bus_a.word_2_out,
            bus_a.word_3_out, bus_a.rx_valid, bus_a.rx_index, bus_a.frame_done,
            bus_a.words_rcvd, bus_a.overrun};
  endfunction

  always @(negedge clk) begin
    if (bus_a.rx_valid) rxq.push_back({bus_a.rx_index, word_a(bus_a.rx_index)});
    if (bus_a.frame_done) begin
      fd_cnt++;
      fd_rcvd = bus_a.words_rcvd;
      fd_ovr  = bus_a.overrun;
    end
    if (!bus_a.miso_oe && bus_a.MISO) viol++;
    if (!bus_b.miso_oe && bus_b.MISO) viol++;
  end

  task automatic set_tx_a(input logic [31:0] tx);
    bus_a.word_0_in = tx[7:0];
    bus_a.word_1_in = tx[15:8];
    bus_a.word_2_in = tx[23:16];
    bus_a.word_3_in = tx[31:24];
  endtask

  // Mode (0,1) master bit: drive on rising SCK, sample MISO at falling SCK.
  task automatic bit_a(input logic mo, output logic mi);
    @(negedge clk);
    bus_a.SCK  = 1'b1;
    bus_a.MOSI = mo;
    repeat (4) @(negedge clk);
    mi = bus_a.MISO;
    bus_a.SCK = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_a(input logic [31:0] tx, input logic [47:0] rx, input int nw, input int pb,
                         input bit chg, input logic [7:0] newv, output logic [47:0] got);
    logic mi;
    int   pos;
    got = '0;
    @(negedge clk);
    set_tx_a(tx);
    bus_a.SS = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nw * 8 + pb; k++) begin
      pos = 8 * (k / 8) + 7 - (k % 8);
      bit_a(rx[pos], mi);
      got[pos] = mi;
      if (chg && k == 2) bus_a.word_1_in = newv;
    end
    repeat (5) @(negedge clk);
    bus_a.SS = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Frame-level expectations: MISO bytes are the snapshot words then zeros, the first
  // min(nw,4) MOSI words are delivered in order, older words persist.
  task automatic model_check(input logic [31:0] tx, input logic [47:0] rx, input int nw,
                             input logic [47:0] got, input int fd_before,
                             input int exp_rcvd, input bit exp_ovr);
    int nrx;
    nrx = (nw > 4) ? 4 : nw;
    for (int j = 0; j < nw; j++)
      chk("miso_byte", got[8*j +: 8], (j < 4) ? tx[8*j +: 8] : 8'h00);
    chk("rx_valid_count", rxq.size(), nrx);
    for (int j = 0; j < nrx; j++) begin
      if (j < rxq.size()) chk("rx_valid_entry", rxq[j], {2'(j), rx[8*j +: 8]});
      exp_word[j] = rx[8*j +: 8];
    end
    rxq.delete();
    chk("word_0_out", bus_a.word_0_out, exp_word[0]);
    chk("word_1_out", bus_a.word_1_out, exp_word[1]);
    chk("word_2_out", bus_a.word_2_out, exp_word[2]);
    chk("word_3_out", bus_a.word_3_out, exp_word[3]);
    chk("frame_done_count", fd_cnt - fd_before, 1);
    chk("words_rcvd", fd_rcvd, exp_rcvd);
    chk("overrun", fd_ovr, exp_ovr);
  endtask

  initial begin
    logic [47:0] got;
    logic [31:0] tx;
    logic [47:0] rx;
    logic [7:0]  mob, gotb;
    logic        mi;
    int          fd0, nw, pb;

    tbl[0] = '{32'hF00F3CA5, 48'h000044332211, 4, 0, 1'b0, 8'h00, 4, 1'b0};
    tbl[1] = '{32'h12345678, 48'h000000E055AA, 2, 3, 1'b0, 8'h00, 2, 1'b0};
    tbl[2] = '{32'hDEADBEEF, 48'h005AC0FFEE01, 5, 0, 1'b0, 8'h00, 4, 1'b1};
    tbl[3] = '{32'hF00F3CA5, 48'h000087654321, 4, 0, 1'b1, 8'h99, 4, 1'b0};
    tbl[4] = '{32'hF00F99A5, 48'h00000000BBAA, 2, 0, 1'b0, 8'h00, 2, 1'b0};
    for (int i = 0; i < 4; i++) exp_word[i] = 8'h00;

    n_rst = 1'b0;
    bus_a.SCK = 1'b0; bus_a.SS = 1'b1; bus_a.MOSI = 1'b0; set_tx_a(32'h0);
    bus_b.SCK = 1'b0; bus_b.SS = 1'b1; bus_b.MOSI = 1'b0;
    bus_b.word_0_in = 8'h00; bus_b.word_1_in = 8'h00;
    bus_b.word_2_in = 8'h00; bus_b.word_3_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec_a(), '0);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      fd0 = fd_cnt;
      frame_a(tbl[i].tx, tbl[i].rx, tbl[i].nw, tbl[i].pb, tbl[i].chg, tbl[i].newv, got);
      model_check(tbl[i].tx, tbl[i].rx, tbl[i].nw, got, fd0, tbl[i].rcvd, tbl[i].ovr);
    end

    // Reset during word 1, then SCK activity while SS stays low must be ignored.
    @(negedge clk);
    set_tx_a(32'h01020304);
    bus_a.SS = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 12; k++) bit_a(1'($urandom), mi);
    #2 n_rst = 1'b0;
    #1 chk("reset_mid_frame_outputs", out_vec_a(), '0);
    for (int i = 0; i < 4; i++) exp_word[i] = 8'h00;
    rxq.delete();
    fd0 = fd_cnt;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 16; k++) bit_a(1'($urandom), mi);
    chk("no_rx_valid_after_reset", rxq.size(), 0);
    repeat (5) @(negedge clk);
    bus_a.SS = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_frame_done_after_reset", fd_cnt - fd0, 0);
    rxq.delete();

    for (int r = 0; r < 14; r++) begin
      tx = $urandom;
      rx = {16'($urandom), 32'($urandom)};
      nw = $urandom_range(0, 6);
      pb = $urandom_range(0, 7);
      fd0 = fd_cnt;
      frame_a(tx, rx, nw, pb, 1'b0, 8'h00, got);
      model_check(tx, rx, nw, got, fd0, (nw > 4) ? 4 : nw, nw > 4);
    end

    // Mode (0,0), LSB first: first bit visible before any SCK edge.
    mob = 8'hC3;
    gotb = 8'h00;
    @(negedge clk);
    bus_b.word_0_in = 8'h81;
    bus_b.word_1_in = 8'($urandom);
    bus_b.MOSI = mob[0];
    bus_b.SS = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_first_bit_before_sck", {bus_b.miso_oe, bus_b.MISO}, 2'b11);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      gotb[i] = bus_b.MISO;
      bus_b.SCK = 1'b1;
      repeat (4) @(negedge clk);
      bus_b.SCK = 1'b0;
      if (i < 7) bus_b.MOSI = mob[i+1];
      repeat (4) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    bus_b.SS = 1'b1;
    repeat (10) @(negedge clk);
    chk("b_miso_byte", gotb, 8'h81);
    chk("b_word_0_out", bus_b.word_0_out, 8'hC3);
    chk("b_words_rcvd", bus_b.words_rcvd, 3'd1);
    chk("b_overrun", bus_b.overrun, 1'b0);

    chk("miso_high_while_disabled", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
